// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues the current PC to a variable-latency instruction memory,
// hands the returned word to decode and steers the PC register's next value.
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC_reg,
  input  logic                   fetch_en,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   dec_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic                   align_err,
  output logic                   fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  state_t                  w_refetch_state;
  logic                    r_imem_req;
  logic                    r_instr_valid;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [PC_WIDTH-1:0]     r_instr_pc;
  logic                    r_align_err;
  logic                    r_fetch_err;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_pend;
  logic [PC_WIDTH-1:2]     r_tgt;

  logic [CNT_WIDTH-1:0]    w_cnt_next;
  logic                    w_pend_next;
  logic [PC_WIDTH-1:2]     w_tgt_next;
  logic                    w_capture;
  logic                    w_fetch_err_next;
  logic                    w_align_err;
  logic [PC_WIDTH-1:0]     w_target_aligned;
  logic [PC_WIDTH-1:0]     w_stored_aligned;
  logic [PC_WIDTH-1:0]     w_pc_plus4;

  assign w_target_aligned = {redirect_target[PC_WIDTH-1:2], 2'b00};
  assign w_stored_aligned = {r_tgt, 2'b00};
  assign w_pc_plus4       = PC + PC_WIDTH'(4);
  // Any transition back towards FETCH parks in IDLE when fetching is disabled.
  assign w_refetch_state  = fetch_en ? S_FETCH : S_IDLE;
  assign w_align_err      = redirect & (|redirect_target[1:0]) & (r_state != S_ERR);

  assign imem_addr   = PC;
  assign imem_req    = r_imem_req;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign align_err   = r_align_err;
  assign fetch_err   = r_fetch_err;

  // Next-state, PC steering and bookkeeping updates.
  always_comb begin
    w_next_state     = r_state;
    PC_reg           = PC;
    w_capture        = 1'b0;
    w_cnt_next       = r_cnt;
    w_pend_next      = r_pend;
    w_tgt_next       = r_tgt;
    w_fetch_err_next = r_fetch_err;
    case (r_state)
      S_IDLE: begin
        if (redirect) PC_reg = w_target_aligned;
        else          PC_reg = PC;
        if (fetch_en) w_next_state = S_FETCH;
        else          w_next_state = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_cnt_next  = '0;
          w_pend_next = 1'b0;
          if (redirect) begin
            PC_reg       = w_target_aligned;
            w_next_state = w_refetch_state;
          end else if (r_pend) begin
            PC_reg       = w_stored_aligned;
            w_next_state = w_refetch_state;
          end else begin
            w_capture    = 1'b1;
            w_next_state = S_VALID;
          end
        end else if (r_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
          w_cnt_next       = '0;
          w_fetch_err_next = 1'b1;
          w_next_state     = S_ERR;
        end else begin
          // The request stays on the bus; a redirect is remembered until the ack.
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
          if (redirect) begin
            w_pend_next = 1'b1;
            w_tgt_next  = redirect_target[PC_WIDTH-1:2];
          end else begin
            w_pend_next = r_pend;
          end
        end
      end
      S_VALID: begin
        if (redirect) begin
          PC_reg       = w_target_aligned;
          w_next_state = w_refetch_state;
        end else if (dec_ready) begin
          PC_reg       = w_pc_plus4;
          w_next_state = w_refetch_state;
        end else begin
          w_next_state = S_VALID;
        end
      end
      S_ERR: begin
        w_next_state = S_ERR;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, handshake outputs and captured instruction registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_align_err   <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      r_tgt         <= '0;
    end else begin
      r_state       <= w_next_state;
      r_imem_req    <= (w_next_state == S_FETCH);
      r_instr_valid <= (w_next_state == S_VALID);
      r_align_err   <= w_align_err;
      r_fetch_err   <= w_fetch_err_next;
      r_cnt         <= w_cnt_next;
      r_pend        <= w_pend_next;
      r_tgt         <= w_tgt_next;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= PC;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a modelled PC register.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic [31:0] PC_reg;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        align_err;
  logic        fetch_err;

  logic        pc_load;
  logic [31:0] pc_load_val;
  int          errs;
  int          checks;

  instr_fetch_unit #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .TIMEOUT(4), .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .PC_reg(PC_reg), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .instr(instr), .instr_pc(instr_pc), .redirect(redirect),
    .redirect_target(redirect_target), .align_err(align_err), .fetch_err(fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The program counter register fed by PC_reg.
  always @(posedge CLK) begin
    if (pc_load) PC <= pc_load_val;
    else         PC <= PC_reg;
  end

  task automatic clear_inputs();
    fetch_en = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dec_ready = 1'b0;
    redirect = 1'b0; redirect_target = 32'h0;
  endtask

  task automatic do_reset(input logic [31:0] pcv);
    @(negedge CLK);
    RST = 1'b1; clear_inputs(); pc_load = 1'b1; pc_load_val = pcv;
    @(negedge CLK);
    RST = 1'b0; pc_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'h0000_0000);
    @(negedge CLK); #1;
    checks++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %0h exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %0h exp 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errs++; $display("FAIL rst_instr: got %h exp 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errs++; $display("FAIL rst_instr_pc: got %h exp 0", instr_pc); end
    checks++; if (align_err !== 1'b0 || fetch_err !== 1'b0) begin errs++; $display("FAIL rst_errs: got %0b%0b exp 00", align_err, fetch_err); end
  endtask

  task automatic test_zero_wait();
    do_reset(32'h0000_0000);
    @(negedge CLK); fetch_en = 1'b1; dec_ready = 1'b1; #1;
    @(negedge CLK); imem_ack = 1'b1; imem_rdata = 32'h2008_0005; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL zw_req: got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    @(negedge CLK); imem_ack = 1'b0; #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005) begin errs++; $display("FAIL zw_instr: got v=%0b %h exp v=1 20080005", instr_valid, instr); end
    checks++; if (instr_pc !== 32'h0) begin errs++; $display("FAIL zw_instr_pc: got %h exp 0", instr_pc); end
    checks++; if (PC_reg !== 32'h4) begin errs++; $display("FAIL zw_pc_reg: got %h exp 4", PC_reg); end
    @(negedge CLK); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errs++; $display("FAIL zw_next_addr: got req=%0b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
  endtask

  task automatic test_wait_stall();
    do_reset(32'h0000_0010);
    @(negedge CLK); fetch_en = 1'b1; #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK); imem_ack = (c == 4); imem_rdata = 32'hAAAA_5555; #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || PC_reg !== 32'h10) begin errs++; $display("FAIL ws_hold%0d: got req=%0b addr=%h pc_reg=%h exp 1 10 10", c, imem_req, imem_addr, PC_reg); end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); imem_ack = 1'b0; dec_ready = 1'b0; #1;
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hAAAA_5555 || instr_pc !== 32'h10 || PC_reg !== 32'h10) begin errs++; $display("FAIL ws_stall%0d: got v=%0b %h pc=%h pc_reg=%h", c, instr_valid, instr, instr_pc, PC_reg); end
    end
    @(negedge CLK); dec_ready = 1'b1; #1;
    checks++; if (PC_reg !== 32'h14) begin errs++; $display("FAIL ws_fire: got %h exp 14", PC_reg); end
    @(negedge CLK); dec_ready = 1'b0; #1;
    checks++; if (PC !== 32'h14 || imem_addr !== 32'h14 || instr_valid !== 1'b0) begin errs++; $display("FAIL ws_once: got pc=%h addr=%h v=%0b exp 14 14 0", PC, imem_addr, instr_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset(32'h0000_0020);
    @(negedge CLK); fetch_en = 1'b1; #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK); redirect = (c == 2); redirect_target = 32'h40; #1;
      checks++; if (imem_addr !== 32'h20 || PC_reg !== 32'h20 || imem_req !== 1'b1) begin errs++; $display("FAIL rw_hold%0d: got addr=%h pc_reg=%h req=%0b exp 20 20 1", c, imem_addr, PC_reg, imem_req); end
    end
    @(negedge CLK); redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (PC_reg !== 32'h40) begin errs++; $display("FAIL rw_pc_reg: got %h exp 40", PC_reg); end
    @(negedge CLK); imem_rdata = 32'h1234_5678; #1;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errs++; $display("FAIL rw_refetch: got v=%0b req=%0b addr=%h exp 0 1 40", instr_valid, imem_req, imem_addr); end
    @(negedge CLK); imem_ack = 1'b0; #1;
    checks++; if (instr !== 32'h1234_5678 || instr_pc !== 32'h40 || instr_valid !== 1'b1) begin errs++; $display("FAIL rw_new_instr: got %h pc=%h v=%0b exp 12345678 40 1", instr, instr_pc, instr_valid); end
  endtask

  task automatic test_redirect_valid();
    do_reset(32'h0000_0080);
    @(negedge CLK); fetch_en = 1'b1; #1;
    @(negedge CLK); imem_ack = 1'b1; imem_rdata = 32'h1111_1111; #1;
    @(negedge CLK); imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h103; dec_ready = 1'b1; #1;
    checks++; if (PC_reg !== 32'h100 || instr_valid !== 1'b1 || align_err !== 1'b0) begin errs++; $display("FAIL rv_redirect: got pc_reg=%h v=%0b ae=%0b exp 100 1 0", PC_reg, instr_valid, align_err); end
    @(negedge CLK); redirect = 1'b0; dec_ready = 1'b0; #1;
    checks++; if (align_err !== 1'b1) begin errs++; $display("FAIL rv_align_pulse: got %0b exp 1", align_err); end
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errs++; $display("FAIL rv_refetch: got v=%0b req=%0b addr=%h exp 0 1 100", instr_valid, imem_req, imem_addr); end
    @(negedge CLK); #1;
    checks++; if (align_err !== 1'b0) begin errs++; $display("FAIL rv_align_clear: got %0b exp 0", align_err); end
  endtask

  task automatic test_timeout();
    do_reset(32'h0000_0200);
    @(negedge CLK); fetch_en = 1'b1; #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK); #1;
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errs++; $display("FAIL to_wait%0d: got req=%0b err=%0b exp 1 0", c, imem_req, fetch_err); end
    end
    @(negedge CLK); #1;
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin errs++; $display("FAIL to_err: got err=%0b req=%0b exp 1 0", fetch_err, imem_req); end
    @(negedge CLK); imem_ack = 1'b1; dec_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h300; #1;
    @(negedge CLK); imem_ack = 1'b0; redirect = 1'b0; #1;
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || PC_reg !== 32'h200) begin errs++; $display("FAIL to_stuck: got err=%0b req=%0b v=%0b pc_reg=%h", fetch_err, imem_req, instr_valid, PC_reg); end
    @(negedge CLK); RST = 1'b1; #1;
    checks++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL to_rst_clear: got %0b exp 0", fetch_err); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset(32'hFFFF_FFFC);
    @(negedge CLK); fetch_en = 1'b1; #1;
    @(negedge CLK); imem_ack = 1'b1; imem_rdata = 32'h0000_0013; #1;
    @(negedge CLK); imem_ack = 1'b0; dec_ready = 1'b1; #1;
    checks++; if (PC_reg !== 32'h0 || instr_pc !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wr_wrap: got pc_reg=%h ipc=%h exp 0 fffffffc", PC_reg, instr_pc); end
    @(negedge CLK); dec_ready = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL wr_addr: got req=%0b addr=%h exp 1 0", imem_req, imem_addr); end
    @(negedge CLK); #1; RST = 1'b1; #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin errs++; $display("FAIL wr_async_rst: got req=%0b v=%0b instr=%h exp 0 0 0", imem_req, instr_valid, instr); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(32'h0000_0000);
    @(negedge CLK); fetch_en = 1'b1; dec_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); imem_ack = 1'b1; imem_rdata = 32'hCAFE_0000 + k; #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errs++; $display("FAIL bb_req%0d: got req=%0b addr=%h exp 1 %h", k, imem_req, imem_addr, 32'(4 * k)); end
      @(negedge CLK); imem_ack = 1'b0; fetch_en = (k != 2); #1;
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0000 + k || instr_pc !== 32'(4 * k) || PC_reg !== 32'(4 * k + 4)) begin errs++; $display("FAIL bb_valid%0d: got v=%0b %h pc=%h pc_reg=%h", k, instr_valid, instr, instr_pc, PC_reg); end
    end
    @(negedge CLK); redirect = 1'b1; redirect_target = 32'h300; #1;
    checks++; if (imem_req !== 1'b0 || PC !== 32'hC || PC_reg !== 32'h300) begin errs++; $display("FAIL bb_idle_redirect: got req=%0b pc=%h pc_reg=%h exp 0 c 300", imem_req, PC, PC_reg); end
    @(negedge CLK); redirect = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || PC !== 32'h300 || align_err !== 1'b0) begin errs++; $display("FAIL bb_idle_hold: got req=%0b pc=%h ae=%0b exp 0 300 0", imem_req, PC, align_err); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    errs = 0; checks = 0;
    RST = 1'b1; pc_load = 1'b1; pc_load_val = 32'h0; clear_inputs();
    test_reset();
    test_zero_wait();
    test_wait_stall();
    test_redirect_wait();
    test_redirect_valid();
    test_timeout();
    test_wrap_and_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting between the program counter register and decode.
- Presents the current PC to a variable-latency instruction memory using a req/ack handshake.
- Captures the returned word and offers it to decode with a valid/ready handshake.
- Drives the program counter's next-value input: holds the PC while stalled, and advances to PC+4 or to a redirect target when an instruction is consumed or redirected.

Parameters:
- PC_WIDTH, 32, width of PC and address buses.
- INSTR_WIDTH, 32, instruction word width.
- TIMEOUT, 255, maximum FETCH cycles without imem_ack before error; minimum 1.
- CNT_WIDTH, 8, wait-counter width; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- PC  in  PC_WIDTH  current program counter register value.
- PC_reg  out  PC_WIDTH  next PC value, registered by the PC register every CLK.
- fetch_en  in  1  allow leaving IDLE.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  PC_WIDTH  read address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  INSTR_WIDTH  read data.
- instr_valid  out  1  instr and instr_pc valid to decode.
- dec_ready  in  1  decode accepts this cycle.
- instr  out  INSTR_WIDTH  fetched instruction.
- instr_pc  out  PC_WIDTH  address instr was fetched from.
- redirect  in  1  branch/jump taken; kill current fetch.
- redirect_target  in  PC_WIDTH  new PC on redirect.
- align_err  out  1  one-cycle pulse: redirect_target[1:0] was nonzero.
- fetch_err  out  1  sticky: memory timeout.

Behaviour:
- States: IDLE, FETCH, VALID, ERR.
- Reset (asynchronous, RST=1):
  - state=IDLE.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, align_err=0, fetch_err=0.
  - wait counter=0, pending-redirect flag=0, stored target=0.
- PC_reg is combinational and equals PC in every cycle not listed below as an advance.
- Any target driven onto PC_reg has bits [1:0] forced to 0. align_err pulses on the following cycle if the raw redirect_target[1:0]!=0.
- IDLE:
  - imem_req=0.
  - fetch_en=1 -> FETCH next cycle.
  - redirect in IDLE -> PC_reg=target for that cycle; remain IDLE.
- FETCH:
  - imem_req=1, imem_addr=PC; both held stable until ack.
  - Wait counter increments each FETCH cycle without ack.
  - imem_ack=1 with no pending redirect:
    - instr<=imem_rdata, instr_pc<=PC, counter<=0.
    - -> VALID.
    - Zero-wait memory (ack in the first FETCH cycle) gives 1-cycle fetch latency.
  - redirect=1 while waiting (no ack): pending<=1, stored target<=target. The outstanding request stays asserted until ack.
  - ack while pending=1:
    - Data discarded, PC_reg=stored target, pending<=0, counter<=0.
    - -> FETCH. The next cycle's request uses the new PC.
  - redirect and ack in the same cycle: data discarded, PC_reg=target -> FETCH.
  - Counter reaches TIMEOUT with no ack: fetch_err<=1, imem_req<=0 -> ERR.
- VALID:
  - instr_valid=1, imem_req=0.
  - instr and instr_pc are held stable until consumed.
  - fire = dec_ready & ~redirect.
  - fire -> PC_reg=PC+4 (wraps modulo 2^PC_WIDTH), instr_valid<=0 -> FETCH.
  - redirect=1 (regardless of dec_ready) -> instruction killed (no handshake), PC_reg=target -> FETCH.
  - fetch_en=0 does not abort a held instruction.
- Re-entering FETCH while fetch_en=0 -> IDLE instead of FETCH. An advance or redirect on that cycle still takes effect.
- ERR:
  - Outputs frozen, PC_reg=PC.
  - Exit only via RST.
- Reset mid-operation: all state and outputs clear immediately; no request is retained. The memory must tolerate a dropped request.
- Throughput: one instruction per two cycles with zero-wait memory and dec_ready held high.

Test Plan:
1. Reset release, fetch_en=1, PC=0x0, zero-wait memory returning 0x20080005 -> imem_req=1 addr=0x0 in cycle 1; instr_valid=1 instr=0x20080005 instr_pc=0x0 in cycle 2 with PC_reg=0x4; next cycle addr=0x4.
2. Memory ack delayed 3 cycles, dec_ready=0 for 2 cycles after valid -> imem_addr stable for 4 cycles; PC_reg=PC throughout; instr stable while valid; advance exactly once.
3. redirect=1 target=0x40 in the 2nd cycle of a 4-cycle wait -> returned data discarded, instr_valid never asserted for it, next imem_addr=0x40.
4. In VALID: redirect=1 target=0x103 with dec_ready=1 -> no fire, PC_reg=0x100, align_err pulses one cycle, next fetch addr=0x100.
5. ack never asserted, TIMEOUT=4 -> fetch_err=1 after 4 FETCH cycles, imem_req=0, stays in ERR until RST; RST clears fetch_err.
6. PC=0xFFFFFFFC consumed -> PC_reg=0x00000000; RST asserted mid-FETCH -> imem_req drops to 0 asynchronously.
